cookie_display_rx: RTL and testbench
====================================

Name: cookie_display_rx

Overview:
- Receive end of the cookie display shift-out link: deserializes the bit stream driven on display_shift_out, qualified by the display strobe, into parallel FRAME_W-bit words.
- Presents each completed word to downstream logic (segment driver / host capture) through a valid/ready handshake.
- Flags framing aborts and overruns with sticky error bits.

Parameters:
- FRAME_W, 16, data bits per frame, range 2..32.
- CNT_W, $clog2(FRAME_W+1), width of the bit counter (derived, do not override).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; when low, no state advances and outputs hold.
- shift_strobe  input  1  high while the transmitter drives a frame bit each cycle.
- shift_bit  input  1  serial data, MSB first, sampled on clk when shift_strobe=1.
- rx_data  output  FRAME_W  last accepted frame word.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_ready  input  1  consumer accepts when rx_valid && rx_ready.
- frame_err  output  1  sticky: strobe dropped mid-frame.
- overrun  output  1  sticky: a frame completed while rx_valid was still high.
- err_clr  input  1  synchronous clear of frame_err, overrun (and parity_err when enabled).
- busy  output  1  high while a frame is partially received.

Behaviour:
- Reset (async, rst_n=0): rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, bit counter=0, shift register=0, state=IDLE.
- All logic advances only when en=1; with en=0 registers hold, including the handshake.
- States:
  - IDLE: shift_strobe=1 samples the first bit (MSB) into the shift register, sets count=1 and moves to SHIFT. busy=1 from the following cycle.
  - SHIFT: each cycle with strobe=1, shift left with shift_bit into the LSB and increment count.
    - When the sampled bit makes count==FRAME_W, the frame completes and the state returns to IDLE the next cycle.
    - strobe=0 with 0<count<FRAME_W is an abort: set frame_err, discard the partial word, return to IDLE, count=0.
  - Back-to-back frames are legal. Strobe held high across a frame boundary starts the next frame on the cycle after completion with no gap; that bit is the new MSB.
- Completion:
  - If rx_valid=0, or rx_valid=1 && rx_ready=1 in the same cycle: load rx_data, rx_valid=1 on the next edge. Latency is 1 cycle after the last bit is sampled.
  - Otherwise (held word not accepted): keep the old rx_data, drop the new word, set overrun.
- Handshake: rx_valid falls the cycle after rx_valid && rx_ready unless a completion loads a new word in that same cycle. rx_data is stable while rx_valid=1.
- err_clr=1 clears the sticky flags. If a new error event occurs in the same cycle, the event wins and the flag stays set.
- Asynchronous reset mid-frame discards the partial word. The first strobe after release starts a fresh frame.

Optional Feature:
- Macro: COOKIE_DISPLAY_RX_PARITY_EN.
- Defined:
  - Each frame carries FRAME_W data bits plus one trailing even-parity bit, so total strobe length is FRAME_W+1. CNT_W covers FRAME_W+1.
  - Output port parity_err (1 bit, sticky, cleared by err_clr).
  - Mismatch sets parity_err and drops the word: no rx_valid and no overrun contribution.
  - A strobe drop before the parity bit counts as frame_err.
- Undefined: the frame is exactly FRAME_W bits, and no parity_err port exists.

Decomposition:
- Shared package cookie_pkg:
  - state enum (IDLE, SHIFT).
  - COOKIE_FRAME_W default constant (16), also used by the transmit side.
  - even-parity function.
- One natural sub-module: cookie_rx_shifter (shift register + bit counter + completion pulse). The top handles the FSM, handshake and error flags.

Test Plan:
- Frame 0xA5C3 MSB-first with 16 strobed cycles, rx_ready=1 → rx_valid high one cycle after the 16th bit, rx_data=0xA5C3, busy low afterward, no errors.
- Two back-to-back frames 0x1234, 0xFFFF with strobe held 32 cycles and rx_ready=0 → rx_data stays 0x1234, overrun=1. Then rx_ready=1 → rx_valid drops; err_clr → overrun=0.
- Strobe drops after 7 bits → frame_err=1, rx_valid stays 0. The next full frame 0x00FF is received correctly.
- en=0 for 5 cycles mid-frame (bits 8..12 presented and ignored), then resume → the received word contains only bits sampled while en=1, count continuity preserved.
- rst_n pulsed low after bit 10 → all outputs 0 immediately. The next 16-bit frame 0xBEEF is received correctly.
- With COOKIE_DISPLAY_RX_PARITY_EN: 0x0001 with parity bit 0 → parity_err=1, no rx_valid. The same word with parity bit 1 → rx_valid, rx_data=0x0001.

Source files
------------

// File: rtl/cookie_pkg.sv
// cookie_pkg
//   Shared definitions for the cookie display shift-out link (used by both the
//   transmit side and cookie_display_rx).
//   - state_t         : receive FSM state encoding
//   - COOKIE_FRAME_W  : default number of data bits per frame
//   - even_parity()   : parity bit that makes the total number of ones even
package cookie_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int COOKIE_FRAME_W = 16;

  // Zero-extended input: leading zeros do not change the parity.
  function automatic logic even_parity(input logic [32:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/cookie_rx_shifter.sv
// cookie_rx_shifter
//   Serial-in shift register plus bit counter for the cookie display receiver.
//   The FSM in the top decides when a bit starts a new frame (i_first) or
//   extends the current one (i_shift); any enabled cycle with neither clears
//   the partial word and the counter.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   i_en       : advance enable; everything holds when low
//   i_first    : load i_bit as the MSB of a new frame, count = 1
//   i_shift    : shift i_bit into the LSB, count + 1
//   i_bit      : serial data
//   o_sr       : shift register contents (complete word while o_done = 1)
//   o_last     : the bit being shifted this cycle completes the frame
//   o_done     : counter sits at full length, i.e. o_sr holds a whole frame
module cookie_rx_shifter #(
  parameter int TOT_W = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_first,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [TOT_W-1:0] o_sr,
  output logic             o_last,
  output logic             o_done
);

  logic [TOT_W-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_first) begin
        r_sr  <= {{(TOT_W-1){1'b0}}, i_bit};
        r_cnt <= CNT_W'(1);
      end else if (i_shift) begin
        r_sr  <= {r_sr[TOT_W-2:0], i_bit};
        r_cnt <= r_cnt + 1'b1;
      end else begin
        // idle, abort, or the cycle after completion without a new frame
        r_sr  <= '0;
        r_cnt <= '0;
      end
    end
  end

  assign o_sr   = r_sr;
  assign o_last = i_shift && (r_cnt == CNT_W'(TOT_W - 1));
  // Only true for the single cycle after the last bit: the following enabled
  // cycle either restarts the counter at 1 or clears it.
  assign o_done = (r_cnt == CNT_W'(TOT_W));

endmodule

// File: rtl/cookie_display_rx.sv
// cookie_display_rx
//   Receive end of the cookie display shift-out link. Deserializes shift_bit
//   (MSB first, qualified by shift_strobe) into FRAME_W-bit words and hands
//   them downstream over a valid/ready handshake. Framing aborts and overruns
//   raise sticky flags cleared by err_clr.
//   Build option COOKIE_DISPLAY_RX_PARITY_EN: each frame carries one trailing
//   even-parity bit and a sticky parity_err output is added.
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   en           : block enable; all state holds while low
//   shift_strobe : frame bit present this cycle
//   shift_bit    : serial data
//   rx_data      : last accepted word (stable while rx_valid)
//   rx_valid     : rx_data holds an unconsumed word
//   rx_ready     : consumer takes the word when rx_valid && rx_ready
//   frame_err    : sticky, strobe dropped mid-frame
//   overrun      : sticky, frame completed while a word was still held
//   err_clr      : synchronous clear of the sticky flags
//   busy         : frame partially received
//   parity_err   : (parity build only) sticky, parity mismatch
//
// state | meaning
// IDLE  | no frame in progress; a strobe here samples the MSB of a new frame
// SHIFT | frame in progress; strobe extends it, strobe low aborts it
module cookie_display_rx
  import cookie_pkg::*;
#(
  parameter int FRAME_W = COOKIE_FRAME_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               shift_strobe,
  input  logic               shift_bit,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               frame_err,
  output logic               overrun,
  input  logic               err_clr,
  output logic               busy
`ifdef COOKIE_DISPLAY_RX_PARITY_EN
  ,
  output logic               parity_err
`endif
);

`ifdef COOKIE_DISPLAY_RX_PARITY_EN
  localparam int TOT_W = FRAME_W + 1;
`else
  localparam int TOT_W = FRAME_W;
`endif
  localparam int CNT_W = $clog2(TOT_W + 1);

  state_t r_state;
  state_t w_state_nxt;

  logic             w_first;
  logic             w_shift;
  logic             w_abort;
  logic             w_busy;
  logic [TOT_W-1:0] w_sr;
  logic             w_last;
  logic             w_done;
  logic             w_par_ok;
  logic             w_take;
  logic             w_can_load;
  logic [FRAME_W-1:0] w_word;

  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_frame_err;
  logic               r_overrun;

  cookie_rx_shifter #(
    .TOT_W (TOT_W),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (en),
    .i_first (w_first),
    .i_shift (w_shift),
    .i_bit   (shift_bit),
    .o_sr    (w_sr),
    .o_last  (w_last),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (shift_strobe) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        // Return to IDLE on the completing bit so a held strobe starts the
        // next frame's MSB on the very next cycle.
        if (!shift_strobe || w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_first = 1'b0;
    w_shift = 1'b0;
    w_abort = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      IDLE: begin
        w_first = shift_strobe;
      end
      SHIFT: begin
        w_shift = shift_strobe;
        w_abort = !shift_strobe;
        w_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_word = w_sr[TOT_W-1 -: FRAME_W];

`ifdef COOKIE_DISPLAY_RX_PARITY_EN
  // Data bits plus the trailing parity bit must hold an even number of ones.
  assign w_par_ok = (even_parity(33'(w_sr)) == 1'b0);
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_take     = w_done && w_par_ok;
  assign w_can_load = !r_rx_valid || rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (en) begin
      if (w_take && w_can_load) begin
        r_rx_data  <= w_word;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      // A new event outranks a simultaneous clear.
      if (w_take && !w_can_load) begin
        r_overrun <= 1'b1;
      end else if (err_clr) begin
        r_overrun <= 1'b0;
      end

      if (w_abort) begin
        r_frame_err <= 1'b1;
      end else if (err_clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

`ifdef COOKIE_DISPLAY_RX_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (en) begin
      if (w_done && !w_par_ok) begin
        r_parity_err <= 1'b1;
      end else if (err_clr) begin
        r_parity_err <= 1'b0;
      end
    end
  end

  assign parity_err = r_parity_err;
`endif

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = w_busy;

endmodule

// File: tb/tb_cookie_display_rx.sv
module tb_cookie_display_rx;

  localparam int FW = 16;
`ifdef COOKIE_DISPLAY_RX_PARITY_EN
  localparam int TOT = FW + 1;
`else
  localparam int TOT = FW;
`endif

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          shift_strobe;
  logic          shift_bit;
  logic [FW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_err;
  logic          overrun;
  logic          err_clr;
  logic          busy;
`ifdef COOKIE_DISPLAY_RX_PARITY_EN
  logic          parity_err;
`endif

  int n_cmp;
  int n_bad;

  cookie_display_rx #(.FRAME_W(FW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .shift_strobe (shift_strobe),
    .shift_bit    (shift_bit),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .err_clr      (err_clr),
    .busy         (busy)
`ifdef COOKIE_DISPLAY_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bit i in transmit order: data MSB first, then the even-parity bit.
  function automatic logic fbit(input logic [FW-1:0] w, input int i);
    if (i < FW) return w[FW-1-i];
    return ^w;
  endfunction

  // Inputs change at the falling edge; the task returns at the next falling
  // edge, i.e. half a cycle after the rising edge that sampled them.
  task automatic cyc(input logic s, input logic b);
    shift_strobe = s;
    shift_bit    = b;
    @(negedge clk);
  endtask

  task automatic send_range(input logic [FW-1:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) cyc(1'b1, fbit(w, i));
  endtask

  task automatic test_reset;
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 16'h0000) begin n_bad++; $display("FAIL reset_rx_data: got %h want 0000", rx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({frame_err, overrun} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {frame_err, overrun}); end
  endtask

  task automatic test_single_frame;
    rx_ready = 1'b1;
    send_range(16'hA5C3, 0, 7);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_mid: got %b want 1", busy); end
    send_range(16'hA5C3, 8, TOT-1);
    n_cmp++; if ({busy, rx_valid} !== 2'b00) begin n_bad++; $display("FAIL single_after_last: got busy,valid=%b want 00", {busy, rx_valid}); end
    cyc(1'b0, 1'b0);
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 16'hA5C3) begin n_bad++; $display("FAIL single_data: got %h want a5c3", rx_data); end
    n_cmp++; if ({frame_err, overrun, busy} !== 3'b000) begin n_bad++; $display("FAIL single_flags: got %b want 000", {frame_err, overrun, busy}); end
    cyc(1'b0, 1'b0);
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL single_consume: got %b want 0", rx_valid); end
  endtask

  task automatic test_back_to_back;
    rx_ready = 1'b0;
    send_range(16'h1234, 0, TOT-1);
    send_range(16'hFFFF, 0, TOT-1);
    cyc(1'b0, 1'b0);
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 16'h1234) begin n_bad++; $display("FAIL b2b_data: got %h want 1234", rx_data); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    rx_ready = 1'b1;
    cyc(1'b0, 1'b0);
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_consume: got %b want 0", rx_valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL b2b_overrun_sticky: got %b want 1", overrun); end
    err_clr = 1'b1;
    cyc(1'b0, 1'b0);
    err_clr = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun_clr: got %b want 0", overrun); end
  endtask

  task automatic test_abort;
    rx_ready = 1'b1;
    send_range(16'h5555, 0, 6);
    cyc(1'b0, 1'b0);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL abort_frame_err: got %b want 1", frame_err); end
    n_cmp++; if ({rx_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL abort_valid_busy: got %b want 00", {rx_valid, busy}); end
    // second abort coinciding with err_clr: the event keeps the flag set
    send_range(16'hFFFF, 0, 2);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL abort_event_wins: got %b want 1", frame_err); end
    cyc(1'b0, 1'b0);
    err_clr = 1'b0;
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL abort_clr: got %b want 0", frame_err); end
    send_range(16'h00FF, 0, TOT-1);
    cyc(1'b0, 1'b0);
    n_cmp++; if ({rx_valid, rx_data} !== {1'b1, 16'h00FF}) begin n_bad++; $display("FAIL abort_next_frame: got valid=%b data=%h want 1 00ff", rx_valid, rx_data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL abort_next_no_err: got %b want 0", frame_err); end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_enable;
    rx_ready = 1'b0;
    send_range(16'h3C5A, 0, 7);
    en = 1'b0;
    for (int i = 8; i <= 12; i++) cyc(1'b1, ~fbit(16'h3C5A, i));
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL en_busy_hold: got %b want 1", busy); end
    en = 1'b1;
    send_range(16'h3C5A, 8, TOT-1);
    cyc(1'b0, 1'b0);
    n_cmp++; if ({rx_valid, rx_data} !== {1'b1, 16'h3C5A}) begin n_bad++; $display("FAIL en_word: got valid=%b data=%h want 1 3c5a", rx_valid, rx_data); end
    en = 1'b0;
    rx_ready = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL en_handshake_hold: got %b want 1", rx_valid); end
    en = 1'b1;
    cyc(1'b0, 1'b0);
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL en_consume: got %b want 0", rx_valid); end
  endtask

  task automatic test_async_reset;
    rx_ready = 1'b0;
    send_range(16'h1111, 0, TOT-1);
    cyc(1'b0, 1'b0);
    send_range(16'hBEEF, 0, 9);
    n_cmp++; if ({rx_valid, busy} !== 2'b11) begin n_bad++; $display("FAIL rst_pre: got valid,busy=%b want 11", {rx_valid, busy}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({rx_valid, busy, frame_err, overrun} !== 4'b0000) begin n_bad++; $display("FAIL rst_async_ctl: got %b want 0000", {rx_valid, busy, frame_err, overrun}); end
    n_cmp++; if (rx_data !== 16'h0000) begin n_bad++; $display("FAIL rst_async_data: got %h want 0000", rx_data); end
    shift_strobe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    send_range(16'hBEEF, 0, TOT-1);
    cyc(1'b0, 1'b0);
    n_cmp++; if ({rx_valid, rx_data} !== {1'b1, 16'hBEEF}) begin n_bad++; $display("FAIL rst_next_frame: got valid=%b data=%h want 1 beef", rx_valid, rx_data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_next_no_err: got %b want 0", frame_err); end
    cyc(1'b0, 1'b0);
  endtask

`ifdef COOKIE_DISPLAY_RX_PARITY_EN
  task automatic test_parity;
    rx_ready = 1'b1;
    send_range(16'h0001, 0, FW-1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    n_cmp++; if (parity_err !== 1'b1) begin n_bad++; $display("FAIL par_err_set: got %b want 1", parity_err); end
    n_cmp++; if ({rx_valid, overrun} !== 2'b00) begin n_bad++; $display("FAIL par_drop: got valid,overrun=%b want 00", {rx_valid, overrun}); end
    send_range(16'h0001, 0, FW-1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    n_cmp++; if ({rx_valid, rx_data} !== {1'b1, 16'h0001}) begin n_bad++; $display("FAIL par_good: got valid=%b data=%h want 1 0001", rx_valid, rx_data); end
    err_clr = 1'b1;
    cyc(1'b0, 1'b0);
    err_clr = 1'b0;
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL par_clr: got %b want 0", parity_err); end
  endtask
`endif

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    en           = 1'b1;
    shift_strobe = 1'b0;
    shift_bit    = 1'b0;
    rx_ready     = 1'b0;
    err_clr      = 1'b0;
    #2;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_abort();
    test_enable();
    test_async_reset();
`ifdef COOKIE_DISPLAY_RX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
